demux_roteamento: RTL and testbench

- Inverse of the 4:1 bus selector: one BITS-wide input stream is routed to one of 2**SEL_BITS output channels, chosen by SEL.
- Each output channel has a one-entry holding register, a valid/ready handshake and a delivered-word counter.
- Sits downstream of a producer and feeds up to four independent consumers; a stalled consumer blocks only traffic addressed to it.

---
 rtl/roteamento_pkg.sv | 18 +
 rtl/canal_saida.sv | 53 +++++
 rtl/demux_roteamento.sv | 49 ++++
 tb/tb_demux_roteamento.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/roteamento_pkg.sv
// Shared widths, word/counter types and the per-channel state encoding
// for the single-input, four-output routing demultiplexer.
package roteamento_pkg;

  localparam int BITS     = 4;
  localparam int SEL_BITS = 2;
  localparam int CNT_BITS = 8;
  localparam int N_SAIDAS = 2 ** SEL_BITS;

  typedef logic [BITS-1:0]     palavra_t;
  typedef logic [CNT_BITS-1:0] contagem_t;

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_canal_t;

endpackage

// File: rtl/canal_saida.sv
// One output channel: a one-word holding register with a valid/ready handshake
// and a wrapping count of words handed to the consumer.
module canal_saida #(
  parameter int BITS     = roteamento_pkg::BITS,
  parameter int CNT_BITS = roteamento_pkg::CNT_BITS
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic [BITS-1:0]     dado,
  input  logic                out_ready,
  output logic                ocupado,
  output logic [BITS-1:0]     Saida,
  output logic                out_valid,
  output logic [CNT_BITS-1:0] Contagem
);
  import roteamento_pkg::*;

  estado_canal_t estado;
  logic          entrega;

  assign entrega = out_valid & out_ready;
  // A full channel can still take a new word in the same cycle its consumer drains it.
  assign ocupado = out_valid & ~out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado    <= VAZIO;
      out_valid <= 1'b0;
      Saida     <= '0;
      Contagem  <= '0;
    end else begin
      if (entrega) begin
        Contagem <= Contagem + 1'b1;
      end
      if (load) begin
        Saida <= dado;
      end
      if (estado == VAZIO) begin
        if (load) begin
          estado    <= CHEIO;
          out_valid <= 1'b1;
        end
      end else begin
        if (entrega && !load) begin
          estado    <= VAZIO;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/demux_roteamento.sv
// Routes one input stream to one of 2**SEL_BITS buffered output channels;
// only the addressed channel's occupancy can stall the producer.
module demux_roteamento #(
  parameter int BITS     = roteamento_pkg::BITS,
  parameter int SEL_BITS = roteamento_pkg::SEL_BITS,
  parameter int CNT_BITS = roteamento_pkg::CNT_BITS
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [BITS-1:0]                       Entrada,
  input  logic [SEL_BITS-1:0]                   SEL,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [2**SEL_BITS-1:0][BITS-1:0]      Saida,
  output logic [2**SEL_BITS-1:0]                out_valid,
  input  logic [2**SEL_BITS-1:0]                out_ready,
  output logic [2**SEL_BITS-1:0][CNT_BITS-1:0]  Contagem
);
  import roteamento_pkg::*;

  localparam int N_CANAIS = 2 ** SEL_BITS;

  logic [N_CANAIS-1:0] ocupado;
  logic [N_CANAIS-1:0] load;

  assign in_ready = reset_n & ~ocupado[SEL];

  generate
    for (genvar gi = 0; gi < N_CANAIS; gi++) begin : g_canal
      assign load[gi] = in_valid & in_ready & (SEL == SEL_BITS'(gi));

      canal_saida #(
        .BITS     (BITS),
        .CNT_BITS (CNT_BITS)
      ) u_canal (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load[gi]),
        .dado      (Entrada),
        .out_ready (out_ready[gi]),
        .ocupado   (ocupado[gi]),
        .Saida     (Saida[gi]),
        .out_valid (out_valid[gi]),
        .Contagem  (Contagem[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_demux_roteamento.sv
// Self-checking bench: directed vector table, hand sequences for counter wrap and
// mid-run reset, then random traffic against a per-channel slot model.
module tb_demux_roteamento;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [3:0]      Entrada;
  logic [1:0]      SEL;
  logic            in_valid;
  logic            in_ready;
  logic [3:0][3:0] Saida;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [3:0][7:0] Contagem;

  always #5 clock = ~clock;

  demux_roteamento dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .Entrada   (Entrada),
    .SEL       (SEL),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Saida     (Saida),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Contagem  (Contagem)
  );

  int checks = 0;
  int errors = 0;

  // Reference: each channel is a slot that is either holding a word or not.
  int m_valid [4];
  int m_dado  [4];
  int m_cnt   [4];
  bit known = 1'b0;

  typedef struct {
    bit         rn;
    int         ent;
    int         sel;
    bit         iv;
    logic [3:0] ordy;
    bit         e_ready;
    logic [3:0] e_valid;
    int         ch;
    int         e_saida;
    int         e_cnt;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_ready(bit rn, int sel, logic [3:0] ordy);
    return rn && ((m_valid[sel] == 0) || ordy[sel]);
  endfunction

  task automatic cycle(input bit rn, input int ent, input int sel, input bit iv,
                       input logic [3:0] ordy, output logic rdy);
    bit acc;
    reset_n   = rn;
    Entrada   = 4'(ent);
    SEL       = 2'(sel);
    in_valid  = iv;
    out_ready = ordy;
    #1;
    rdy = in_ready;
    if (known) chk("in_ready", 32'(in_ready), 32'(m_ready(rn, sel, ordy)));
    acc = iv && m_ready(rn, sel, ordy);
    @(posedge clock);
    #1;
    if (!rn) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 0;
        m_dado[i]  = 0;
        m_cnt[i]   = 0;
      end
      known = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i] != 0 && ordy[i]) m_cnt[i] = (m_cnt[i] + 1) % 256;
        if (acc && sel == i) begin
          m_valid[i] = 1;
          m_dado[i]  = ent % 16;
        end else if (ordy[i]) begin
          m_valid[i] = 0;
        end
      end
    end
    if (known) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_valid[i]));
        chk($sformatf("Saida[%0d]", i), 32'(Saida[i]), 32'(m_dado[i]));
        chk($sformatf("Contagem[%0d]", i), 32'(Contagem[i]), 32'(m_cnt[i]));
      end
    end
    $display("t=%0t rn=%0d sel=%0d ent=%0h iv=%0d ordy=%b in_ready=%0d -> valid=%b cnt=%0d/%0d/%0d/%0d",
             $time, rn, sel, ent % 16, iv, ordy, rdy, out_valid,
             Contagem[0], Contagem[1], Contagem[2], Contagem[3]);
  endtask

  initial begin
    logic rdy;
    reset_n   = 1'b0;
    Entrada   = '0;
    SEL       = '0;
    in_valid  = 1'b0;
    out_ready = '0;

    //          rn ent  sel iv ordy     rdy valid    ch saida cnt
    tbl.push_back('{0, 0,   0, 0, 4'b0000, 0, 4'b0000, 0, 0,   0});
    tbl.push_back('{0, 0,   0, 0, 4'b0000, 0, 4'b0000, 3, 0,   0});
    tbl.push_back('{1, 0,   0, 0, 4'b0000, 1, 4'b0000, 1, 0,   0});
    tbl.push_back('{1, 0,   3, 0, 4'b0000, 1, 4'b0000, 2, 0,   0});
    tbl.push_back('{1, 'hA, 2, 1, 4'b0000, 1, 4'b0100, 2, 'hA, 0});
    tbl.push_back('{1, 0,   0, 0, 4'b0100, 1, 4'b0000, 2, 'hA, 1});
    tbl.push_back('{1, 6,   1, 1, 4'b0000, 1, 4'b0010, 1, 6,   0});
    tbl.push_back('{1, 9,   1, 1, 4'b0000, 0, 4'b0010, 1, 6,   0});
    tbl.push_back('{1, 5,   3, 1, 4'b0000, 1, 4'b1010, 3, 5,   0});
    tbl.push_back('{1, 0,   0, 0, 4'b1010, 1, 4'b0000, 1, 6,   1});
    tbl.push_back('{1, 1,   0, 1, 4'b0001, 1, 4'b0001, 0, 1,   0});
    tbl.push_back('{1, 2,   0, 1, 4'b0001, 1, 4'b0001, 0, 2,   1});
    tbl.push_back('{1, 3,   0, 1, 4'b0001, 1, 4'b0001, 0, 3,   2});
    tbl.push_back('{1, 4,   0, 1, 4'b0001, 1, 4'b0001, 0, 4,   3});
    tbl.push_back('{1, 0,   0, 0, 4'b0001, 1, 4'b0000, 0, 4,   4});

    foreach (tbl[k]) begin
      cycle(tbl[k].rn, tbl[k].ent, tbl[k].sel, tbl[k].iv, tbl[k].ordy, rdy);
      chk($sformatf("vec%0d in_ready", k), 32'(rdy), 32'(tbl[k].e_ready));
      chk($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(tbl[k].e_valid));
      chk($sformatf("vec%0d Saida[%0d]", k, tbl[k].ch), 32'(Saida[tbl[k].ch]), 32'(tbl[k].e_saida));
      chk($sformatf("vec%0d Contagem[%0d]", k, tbl[k].ch), 32'(Contagem[tbl[k].ch]), 32'(tbl[k].e_cnt));
    end

    // Counter wrap on channel 3 while it streams back-to-back.
    for (int n = 0; n < 300; n++) begin
      cycle(1, int'($urandom_range(15)), 3, 1, 4'b1000, rdy);
      if (m_cnt[3] == 255) break;
    end
    chk("wrap Contagem[3] at 255", 32'(Contagem[3]), 32'd255);
    cycle(1, 0, 0, 0, 4'b1000, rdy);
    chk("wrap Contagem[3] to 0", 32'(Contagem[3]), 32'd0);
    chk("wrap Contagem[0] kept", 32'(Contagem[0]), 32'd4);
    chk("wrap Contagem[1] kept", 32'(Contagem[1]), 32'd1);
    chk("wrap Contagem[2] kept", 32'(Contagem[2]), 32'd1);
    chk("wrap out_valid drained", 32'(out_valid), 32'd0);

    // Build channels 0 and 2 full with Contagem[0]=7, then pulse reset.
    cycle(1, 1, 0, 1, 4'b0000, rdy);
    cycle(1, 2, 0, 1, 4'b0001, rdy);
    cycle(1, 3, 0, 1, 4'b0001, rdy);
    cycle(1, 4, 0, 1, 4'b0001, rdy);
    chk("pre-reset Contagem[0]", 32'(Contagem[0]), 32'd7);
    cycle(1, 7, 2, 1, 4'b0000, rdy);
    chk("pre-reset out_valid", 32'(out_valid), 32'b0101);
    cycle(0, 0, 0, 0, 4'b0000, rdy);
    chk("mid-reset in_ready", 32'(rdy), 32'd0);
    chk("mid-reset out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("mid-reset Contagem[%0d]", i), 32'(Contagem[i]), 32'd0);
    cycle(1, 'hA, 0, 1, 4'b0000, rdy);
    chk("post-reset route out_valid", 32'(out_valid), 32'b0001);
    chk("post-reset route Saida[0]", 32'(Saida[0]), 32'hA);
    cycle(1, 0, 1, 0, 4'b0001, rdy);
    chk("post-reset deliver Contagem[0]", 32'(Contagem[0]), 32'd1);
    chk("post-reset deliver out_valid", 32'(out_valid), 32'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(63) != 0), int'($urandom_range(15)), int'($urandom_range(3)),
            ($urandom_range(3) != 0), 4'($urandom), rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
